// File: rtl/ps2_device_tx.sv
// ps2_device_tx: PS/2 device-side transmitter with byte FIFO, idle gap and inhibit retry.
// Define PS2_HOST_RX_EN to also receive host-to-device command frames.
module ps2_device_tx #(
  parameter int SYSCLK_FREQUENCY = 500,
  parameter int PS2_CLK_KHZ = 12,
  parameter int FIFO_AW = 3,
  parameter int IDLE_HALVES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic [7:0] tx_data,
  input  logic tx_valid,
  output logic tx_ready,
  output logic [FIFO_AW:0] fifo_count,
  input  logic ps2_clk_in,
  input  logic ps2_dat_in,
  output logic ps2_clk_out,
  output logic ps2_dat_out,
  output logic busy,
  output logic abort_pulse,
  output logic [7:0] rx_data,
  output logic rx_valid,
  output logic rx_error
);
  localparam int HALF = SYSCLK_FREQUENCY * 50 / PS2_CLK_KHZ;
  localparam int TW = $clog2(IDLE_HALVES * HALF + 1);
  localparam logic [TW-1:0] HALF_END = TW'(HALF - 1);
  localparam logic [TW-1:0] IDLE_END = TW'(IDLE_HALVES * HALF);
  localparam logic [TW-1:0] T1 = TW'(1);
  localparam logic [FIFO_AW:0] P1 = (FIFO_AW + 1)'(1);
  typedef enum logic [2:0] {IDLE, SETUP, LOW, DONE, ABORT, RX} state_t;
  state_t state;
  logic clk_m, clk_s, dat_m, dat_s, drv_m, drv_s;
  logic [7:0] mem [2**FIFO_AW];
  logic [FIFO_AW:0] wr_ptr, rd_ptr;
  logic push, pop, empty;
  logic [7:0] head;
  logic [15:0] frame;
  logic [TW-1:0] timer, idle_cnt;
  logic [3:0] idx, nxt;
  // drv_* delays our own clock drive so it lines up with the synchronised line
  always_ff @(posedge clk)
    if (reset) {clk_m, clk_s, dat_m, dat_s, drv_m, drv_s} <= '1;
    else {clk_m, clk_s, dat_m, dat_s, drv_m, drv_s} <= {ps2_clk_in, clk_m, ps2_dat_in, dat_m, ps2_clk_out, drv_m};
  assign fifo_count = wr_ptr - rd_ptr;
  assign tx_ready = !fifo_count[FIFO_AW];
  assign empty = fifo_count == '0;
  assign push = tx_valid && tx_ready;
  assign pop = state == DONE;
  assign head = mem[rd_ptr[FIFO_AW-1:0]];
  assign frame = {6'h3f, ~^head, head, 1'b0};
  assign nxt = idx + 4'd1;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[FIFO_AW-1:0]] <= tx_data;
  always_ff @(posedge clk)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= push ? wr_ptr + P1 : wr_ptr;
      rd_ptr <= pop ? rd_ptr + P1 : rd_ptr;
    end
`ifdef PS2_HOST_RX_EN
  localparam logic [TW-1:0] MID = TW'(HALF / 2 - 1);
  logic inh;
  logic [TW-1:0] req_cnt;
  logic [9:0] rx_sh;
`else
  assign rx_data = '0;
  assign rx_valid = 1'b0;
  assign rx_error = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      timer <= '0;
      idle_cnt <= '0;
      idx <= '0;
      ps2_clk_out <= 1'b1;
      ps2_dat_out <= 1'b1;
      busy <= 1'b0;
      abort_pulse <= 1'b0;
`ifdef PS2_HOST_RX_EN
      inh <= 1'b0;
      req_cnt <= '0;
      rx_sh <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      rx_error <= 1'b0;
`endif
    end else begin
      abort_pulse <= 1'b0;
`ifdef PS2_HOST_RX_EN
      rx_valid <= 1'b0;
`endif
      case (state)
        IDLE: begin
          idle_cnt <= (!(clk_s && dat_s) || empty) ? '0 : (idle_cnt == IDLE_END) ? idle_cnt : idle_cnt + T1;
`ifdef PS2_HOST_RX_EN
          // a request is clock released with data held low, after an inhibit
          inh <= !clk_s || (inh && !dat_s);
          req_cnt <= (clk_s && !dat_s && inh) ? req_cnt + T1 : '0;
          if (req_cnt == HALF_END) begin
            state <= RX;
            timer <= '0;
            idx <= '0;
            inh <= 1'b0;
            req_cnt <= '0;
          end
`endif
          if (idle_cnt == IDLE_END) begin
            state <= SETUP;
            idx <= '0;
            timer <= '0;
            idle_cnt <= '0;
            ps2_dat_out <= frame[0];
            busy <= 1'b1;
          end
        end
        SETUP: begin
          if (!clk_s && drv_s) begin
            state <= ABORT;
            ps2_dat_out <= 1'b1;
            busy <= 1'b0;
            abort_pulse <= 1'b1;
          end else if (timer == HALF_END) begin
            state <= LOW;
            ps2_clk_out <= 1'b0;
            timer <= '0;
          end else timer <= timer + T1;
        end
        LOW: begin
          if (timer == HALF_END) begin
            timer <= '0;
            ps2_clk_out <= 1'b1;
            if (idx == 4'd10) begin
              state <= DONE;
              ps2_dat_out <= 1'b1;
            end else begin
              state <= SETUP;
              idx <= nxt;
              ps2_dat_out <= frame[nxt];
            end
          end else timer <= timer + T1;
        end
        DONE: begin
          state <= IDLE;
          busy <= 1'b0;
        end
        ABORT: state <= IDLE;
`ifdef PS2_HOST_RX_EN
        RX: begin
          timer <= (timer == HALF_END) ? '0 : timer + T1;
          if (ps2_clk_out && timer == MID) rx_sh <= {dat_s, rx_sh[9:1]};
          if (timer == HALF_END) begin
            ps2_clk_out <= !ps2_clk_out;
            if (ps2_clk_out) ps2_dat_out <= idx != 4'd10;
            else if (idx == 4'd10) begin
              state <= IDLE;
              ps2_dat_out <= 1'b1;
              rx_valid <= 1'b1;
              rx_data <= rx_sh[7:0];
              rx_error <= !(^rx_sh[8:0]) || !rx_sh[9];
            end else idx <= nxt;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ps2_device_tx.sv
// tb_ps2_device_tx: directed bench for ps2_device_tx with a loopback host line model (HALF = 50).
`timescale 1ns/1ps
module tb_ps2_device_tx;
  logic clk = 1'b0, reset = 1'b1;
  logic [7:0] tx_data = '0;
  logic tx_valid = 1'b0;
  logic tx_ready, ps2_clk_out, ps2_dat_out, busy, abort_pulse, rx_valid, rx_error;
  logic [3:0] fifo_count;
  logic [7:0] rx_data;
  logic host_clk_low = 1'b0, host_dat_low = 1'b0;
  logic ps2_clk_in, ps2_dat_in;
  int checks = 0, errors = 0, aborts = 0, rx_pulses = 0;
  logic [7:0] rx_last = '0;
  logic rx_err_last = 1'b0;
  assign ps2_clk_in = ps2_clk_out & ~host_clk_low;
  assign ps2_dat_in = ps2_dat_out & ~host_dat_low;
  always #5 clk = ~clk;
  ps2_device_tx #(.SYSCLK_FREQUENCY(12), .PS2_CLK_KHZ(12)) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .fifo_count(fifo_count), .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in),
    .ps2_clk_out(ps2_clk_out), .ps2_dat_out(ps2_dat_out), .busy(busy), .abort_pulse(abort_pulse),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_error(rx_error)
  );
  always @(negedge clk) begin
    if (abort_pulse) aborts++;
    if (rx_valid) begin
      rx_pulses++;
      rx_last = rx_data;
      rx_err_last = rx_error;
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction
  task automatic push(input logic [7:0] b);
    tx_data = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask
  task automatic wait_clk(input logic v, input int limit, output int n);
    n = 0;
    while (ps2_clk_out !== v && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (n >= limit) check("wait_clk_timeout", ps2_clk_out, v);
  endtask
  // mode 1: push extra on the pop cycle; mode 2: host pulls clock low after the 11th fall
  task automatic recv(input int mode, input logic [7:0] extra, output logic [10:0] bits,
                      output int lead, output int min_w, output int max_w,
                      output int cnt_pre, output int cnt_post);
    int n;
    min_w = 1 << 30;
    max_w = 0;
    bits = '0;
    wait_clk(1'b0, 1000, lead);
    for (int i = 0; i < 11; i++) begin
      if (i > 0) wait_clk(1'b0, 200, n);
      bits[i] = ps2_dat_out;
      if (i == 10 && mode == 2) host_clk_low = 1'b1;
      wait_clk(1'b1, 200, n);
      min_w = n < min_w ? n : min_w;
      max_w = n > max_w ? n : max_w;
    end
    cnt_pre = fifo_count;
    if (mode == 1) begin
      tx_data = extra;
      tx_valid = 1'b1;
    end
    @(negedge clk);
    tx_valid = 1'b0;
    cnt_post = fifo_count;
  endtask
`ifdef PS2_HOST_RX_EN
  task automatic host_send(input logic [7:0] b, input logic par, output logic ack, output int pulses);
    logic [9:0] seq;
    int n;
    seq = {1'b1, par, b};
    ack = 1'b1;
    pulses = 0;
    host_clk_low = 1'b1;
    repeat (300) @(negedge clk);
    host_dat_low = 1'b1;
    repeat (10) @(negedge clk);
    host_clk_low = 1'b0;
    for (int k = 0; k < 11; k++) begin
      wait_clk(1'b0, 1000, n);
      if (k < 10) host_dat_low = ~seq[k];
      else ack = ps2_dat_out;
      wait_clk(1'b1, 200, n);
      pulses++;
    end
    repeat (200) @(negedge clk) if (!ps2_clk_out) pulses++;
  endtask
`endif
  logic [10:0] bits;
  int lead, min_w, max_w, cpre, cpost, a0, n, lows, r0;
  logic [7:0] exp_q [9] = '{8'hF0, 8'h1C, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h99};
`ifdef PS2_HOST_RX_EN
  logic ack;
  int pulses;
`endif
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    repeat (4) @(negedge clk);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_clk_out", ps2_clk_out, 1);
    check("rst_dat_out", ps2_dat_out, 1);
    check("rst_busy", busy, 0);
    check("rst_abort", abort_pulse, 0);
    check("rst_rx", {rx_data, rx_valid, rx_error}, 0);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    // single byte 0x1C: 0,0,0,1,1,1,0,0,0,0,1 on successive falling edges
    push(8'h1C);
    check("single_count", fifo_count, 1);
    recv(0, 8'h00, bits, lead, min_w, max_w, cpre, cpost);
    check("single_bits", bits, 11'h438);
    check("single_start_delay", lead >= 245 && lead <= 260, 1);
    check("single_min_w", min_w, 50);
    check("single_max_w", max_w, 50);
    check("single_cnt_pre", cpre, 1);
    check("single_cnt_post", cpost, 0);
    check("single_busy_fall", busy, 0);
    // fill the FIFO, overflow push, then drain with a push on a pop cycle
    for (int i = 0; i < 8; i++) push(exp_q[i]);
    check("full_count", fifo_count, 8);
    check("full_ready", tx_ready, 0);
    push(8'h77);
    check("full_ignored", fifo_count, 8);
    for (int k = 0; k < 9; k++) begin
      recv(k == 1 ? 1 : 0, 8'h99, bits, lead, min_w, max_w, cpre, cpost);
      check($sformatf("q_bits_%0d", k), bits, frame_of(exp_q[k]));
      if (k == 0) begin
        check("q_pop_pre", cpre, 8);
        check("q_pop_post", cpost, 7);
        check("q_ready_after_pop", tx_ready, 1);
      end
      if (k == 1) begin
        check("q_pushpop_pre", cpre, 7);
        check("q_pushpop_post", cpost, 7);
        check("q_gap", lead >= 245 && lead <= 260, 1);
      end
    end
    check("q_empty", fifo_count, 0);
    // inhibit during SETUP of bit 4 of 0xAA
    push(8'hAA);
    for (int i = 0; i < 4; i++) begin
      wait_clk(1'b0, 1000, n);
      wait_clk(1'b1, 200, n);
    end
    repeat (10) @(negedge clk);
    a0 = aborts;
    host_clk_low = 1'b1;
    repeat (300) @(negedge clk);
    check("inh_abort_cycles", aborts - a0, 1);
    check("inh_clk_rel", ps2_clk_out, 1);
    check("inh_dat_rel", ps2_dat_out, 1);
    check("inh_count", fifo_count, 1);
    check("inh_busy", busy, 0);
    host_clk_low = 1'b0;
    recv(0, 8'h00, bits, lead, min_w, max_w, cpre, cpost);
    check("inh_resend_bits", bits, frame_of(8'hAA));
    check("inh_resend_gap", lead >= 245 && lead <= 260, 1);
    check("inh_cnt_pre", cpre, 1);
    check("inh_cnt_post", cpost, 0);
    // late inhibit right after the 11th falling edge
    push(8'h5A);
    a0 = aborts;
    recv(2, 8'h00, bits, lead, min_w, max_w, cpre, cpost);
    repeat (100) @(negedge clk);
    host_clk_low = 1'b0;
    check("late_bits", bits, frame_of(8'h5A));
    check("late_no_abort", aborts - a0, 0);
    check("late_popped", cpost, 0);
    // data held low without an inhibit only stalls the start
    r0 = rx_pulses;
    host_dat_low = 1'b1;
    push(8'h3C);
    lows = 0;
    repeat (600) @(negedge clk) if (!ps2_clk_out || busy) lows++;
    check("dat_low_stall", lows, 0);
    check("dat_low_no_rx", rx_pulses - r0, 0);
    host_dat_low = 1'b0;
    recv(0, 8'h00, bits, lead, min_w, max_w, cpre, cpost);
    check("dat_low_bits", bits, frame_of(8'h3C));
    // reset while bit 6 of 0x96 is on the line
    push(8'h96);
    for (int i = 0; i < 7; i++) begin
      wait_clk(1'b0, 1000, n);
      if (i < 6) wait_clk(1'b1, 200, n);
    end
    check("mid_pre_dat", ps2_dat_out, 0);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_clk", ps2_clk_out, 1);
    check("mid_rst_dat", ps2_dat_out, 1);
    check("mid_rst_count", fifo_count, 0);
    check("mid_rst_ready", tx_ready, 1);
    reset = 1'b0;
    repeat (20) @(negedge clk);
`ifdef PS2_HOST_RX_EN
    r0 = rx_pulses;
    host_send(8'hED, 1'b1, ack, pulses);
    check("rx_valid_pulse", rx_pulses - r0, 1);
    check("rx_data", rx_last, 8'hED);
    check("rx_error_good", rx_err_last, 0);
    check("rx_ack", ack, 0);
    check("rx_pulses", pulses, 11);
    host_send(8'hED, 1'b0, ack, pulses);
    check("rx_valid_pulse_bad", rx_pulses - r0, 2);
    check("rx_error_bad", rx_err_last, 1);
`else
    check("rx_off_outputs", {rx_data, rx_valid, rx_error}, 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
